regfile_2r1w_param: RTL and testbench
=====================================

Name: regfile_2r1w_param

Overview:
Parametrised register file with two combinational read ports and one synchronous write port. It is the next-generation datapath register file for the processor pipeline, providing operand reads for rs1/rs2 and writeback in one cycle. It adds a hardware clear sequencer that zeroes every entry after reset or on request. It also reports busy and dropped-write status to the control unit.

Parameters:
NREGS, 32, number of entries (power of two, >= 2)
DATA_W, 32, bits per entry
ZERO_REG, 1, when 1 entry 0 is hardwired: reads return 0 and writes are discarded
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
clear_req  input  1  request full clear; sampled only in READY
busy  output  1  high while clear sequencer runs (INIT or CLEAR)
wen  input  1  write enable
waddr  input  AW  write address
wdata  input  DATA_W  write data
wr_drop  output  1  combinational; high when wen=1 and the write is discarded for busy or clear reasons
raddr0  input  AW  read port 0 address
rdata0  output  DATA_W  read port 0 data (combinational)
raddr1  input  AW  read port 1 address
rdata1  output  DATA_W  read port 1 data (combinational)

Behaviour:
- FSM states: INIT, READY, CLEAR. Counter clr_ptr is AW bits.
- Reset (async, any cycle, including mid-clear): state=INIT, clr_ptr=0. Storage array itself is not reset. busy=1 while rst high.
- INIT/CLEAR: each posedge writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr==NREGS-1, that entry is written, clr_ptr wraps to 0 and state goes to READY.
  - A clear therefore takes exactly NREGS cycles. busy falls NREGS cycles after the first posedge with rst low.
- READY, clear_req=1: next state CLEAR, clr_ptr=0, busy=1 from the next cycle. Any write presented in that same cycle is discarded and wr_drop=1 (clear wins).
- clear_req is ignored in INIT/CLEAR. The sequence does not restart.
- Write, READY only: if wen=1, clear_req=0, and not (ZERO_REG=1 and waddr=0), then entry[waddr]<=wdata at posedge.
  - Writes to entry 0 with ZERO_REG=1 are discarded silently (wr_drop=0).
- wr_drop = wen & (busy | clear_req). Must be 0 when wen=0.
- Reads (each port independent and identical):
  - rdata=0 if busy=1.
  - Else rdata=0 if ZERO_REG=1 and raddr=0.
  - Else rdata=entry[raddr].
- Same-cycle waddr==raddr: read returns the old (pre-write) value. New value is visible the next cycle. Exception: see the optional feature.
- Both ports may read the same address simultaneously with identical results.
- Outputs after reset: busy=1, rdata0=rdata1=0, wr_drop=wen.

Optional Feature:
REGFILE_WR_BYPASS_EN
- Defined: when a write is accepted this cycle (READY, wen=1, clear_req=0, not a zero-reg discard) and raddrN==waddr, rdataN=wdata combinationally. This gives write-to-read forwarding on both ports. Discarded writes are never forwarded.
- Undefined: no forwarding; same-cycle reads return old data as above.

Test Plan:
- Reset, NREGS=32: rst high 2 cycles then low -> busy=1 for exactly 32 posedges, then 0. All 32 entries read 0 on both ports.
- READY: write 0xDEADBEEF to r5, then read raddr0=5, raddr1=5 next cycle -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0, wr_drop=0.
- Same-cycle write r7=0xA5A5A5A5 (r7 held 0x11) with raddr0=7 -> rdata0=0x11 without the macro, 0xA5A5A5A5 with REGFILE_WR_BYPASS_EN. Next cycle it reads 0xA5A5A5A5 either way.
- Fill r1..r31 with index values, pulse clear_req with simultaneous wen to r3=0xFF -> wr_drop=1 that cycle. busy=1 for 32 cycles, then all reads 0 and r3 is not 0xFF.
- During CLEAR at clr_ptr=10, assert rst asynchronously mid-cycle -> busy stays 1 and the clear restarts at 0, finishing 32 cycles after rst falls. Writes during busy give wr_drop=1 and do not modify storage.
- ZERO_REG=0, NREGS=8, DATA_W=16: write r0=0xBEEF, read r0 -> 0xBEEF. busy lasts 8 cycles after reset.

Source files
------------

// File: rtl/regfile_2r1w_param.sv
// Two-read / one-write register file with a hardware clear sequencer and busy/drop status.
// Optional write-to-read forwarding on both ports is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_2r1w_param #(
  parameter  int NREGS    = 32,
  parameter  int DATA_W   = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_drop,
  input  logic [AW-1:0]     raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1
);

  typedef enum logic [1:0] {INIT, READY, CLEAR} state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [NREGS];
  logic                w_zero_wr, w_wr_acc;
  logic [1:0][AW-1:0]     w_raddr;
  logic [1:0][DATA_W-1:0] w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // The clear pointer wraps to 0 on its own after the last entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      INIT, CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == AW'(NREGS-1)) w_state_nxt = READY;
      end
      READY: begin
        if (clear_req) begin
          w_state_nxt   = CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy = (r_state != READY);
  end

  assign w_zero_wr = (ZERO_REG != 0) && (waddr == '0);
  assign w_wr_acc  = !busy && wen && !clear_req && !w_zero_wr;
  assign wr_drop   = wen & (busy | clear_req);

  always_ff @(posedge clk) begin
    if (busy)          r_mem[r_clr_ptr] <= '0;
    else if (w_wr_acc) r_mem[waddr]     <= wdata;
  end

  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rdata[p] = r_mem[w_raddr[p]];
      if (busy)
        w_rdata[p] = '0;
      else if ((ZERO_REG != 0) && (w_raddr[p] == '0))
        w_rdata[p] = '0;
`ifdef REGFILE_WR_BYPASS_EN
      else if (w_wr_acc && (w_raddr[p] == waddr))
        w_rdata[p] = wdata;
`endif
    end
  end

  assign rdata0 = w_rdata[0];
  assign rdata1 = w_rdata[1];

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Bench for regfile_2r1w_param: vector table, clear/reset sequences and random traffic vs. a reference model.
module tb_regfile_2r1w_param;
  localparam int N = 32;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, clear_req, wen, busy, wr_drop;
  logic [4:0]  waddr, raddr0, raddr1;
  logic [31:0] wdata, rdata0, rdata1;

  logic        rst_s, clr_s, wen_s, busy_s, drop_s;
  logic [2:0]  wa_s, ra0_s, ra1_s;
  logic [15:0] wd_s, rd0_s, rd1_s;

  int checks = 0, failures = 0;

  regfile_2r1w_param #(.NREGS(32), .DATA_W(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy), .wen(wen), .waddr(waddr),
    .wdata(wdata), .wr_drop(wr_drop), .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1));

  regfile_2r1w_param #(.NREGS(8), .DATA_W(16), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst(rst_s), .clear_req(clr_s), .busy(busy_s), .wen(wen_s), .waddr(wa_s),
    .wdata(wd_s), .wr_drop(drop_s), .raddr0(ra0_s), .rdata0(rd0_s), .raddr1(ra1_s), .rdata1(rd1_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents array plus remaining busy cycles.
  logic [31:0] m_mem [N];
  int          busy_left;

  always @(posedge clk or posedge rst) begin
    if (rst) busy_left = N;
    else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
    end
    else if (clear_req) busy_left = N;
    else if (wen && waddr != 5'd0) m_mem[waddr] = wdata;
  end

  function automatic bit exp_busy();
    return rst || (busy_left > 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (exp_busy()) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (BYP && wen && !clear_req && waddr != 5'd0 && a == waddr) return wdata;
    return m_mem[a];
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    cmp("busy", {31'h0, busy}, {31'h0, exp_busy()});
    cmp("wr_drop", {31'h0, wr_drop}, {31'h0, wen && (exp_busy() || clear_req)});
    cmp("rdata0", rdata0, exp_rd(raddr0));
    cmp("rdata1", rdata1, exp_rd(raddr1));
  endtask

  task automatic drv(input bit we, input logic [4:0] wa, input logic [31:0] wd, input bit cr,
                     input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    wen = we; waddr = wa; wdata = wd; clear_req = cr; raddr0 = a0; raddr1 = a1;
    #1;
  endtask

  // Counts posedges until busy drops; starts just after an edge or at a negedge.
  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask

  typedef struct {
    bit we; logic [4:0] wa; logic [31:0] wd; bit cr; logic [4:0] a0, a1;
    logic [31:0] e0, e1; bit edrop;
  } vec_t;
  vec_t tv [9];

  int n;

  initial begin
    tv[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0};
    tv[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tv[2] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    tv[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    tv[4] = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd7,  5'd5,  BYP ? 32'h11 : 32'h0, 32'hDEADBEEF, 1'b0};
    tv[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd7,  5'd7,  BYP ? 32'hA5A5A5A5 : 32'h11, BYP ? 32'hA5A5A5A5 : 32'h11, 1'b0};
    tv[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    tv[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd31, 5'd7,  BYP ? 32'hCAFEF00D : 32'h0, 32'hA5A5A5A5, 1'b0};
    tv[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};

    rst = 1'b1; clear_req = 1'b0; wen = 1'b1; waddr = 5'd3; wdata = 32'h0; raddr0 = 5'd4; raddr1 = 5'd9;
    rst_s = 1'b1; clr_s = 1'b0; wen_s = 1'b0; wa_s = 3'd0; wd_s = 16'h0; ra0_s = 3'd0; ra1_s = 3'd0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    cmp("rst_busy", {31'h0, busy}, 32'h1);
    cmp("rst_drop", {31'h0, wr_drop}, 32'h1);
    cmp("rst_rd0", rdata0, 32'h0);
    cmp("rst_rd1", rdata1, 32'h0);
    @(negedge clk); rst = 1'b0; wen = 1'b0;
    wait_ready(n);
    cmp("init_len", n, 32);
    for (int i = 0; i < N; i++) begin
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
      cmp("init_rd0", rdata0, 32'h0);
      cmp("init_rd1", rdata1, 32'h0);
    end

    // Vector table
    for (int i = 0; i < 9; i++) begin
      drv(tv[i].we, tv[i].wa, tv[i].wd, tv[i].cr, tv[i].a0, tv[i].a1);
      cmp($sformatf("tv%0d_rd0", i), rdata0, tv[i].e0);
      cmp($sformatf("tv%0d_rd1", i), rdata1, tv[i].e1);
      cmp($sformatf("tv%0d_drop", i), {31'h0, wr_drop}, {31'h0, tv[i].edrop});
      cmp($sformatf("tv%0d_busy", i), {31'h0, busy}, 32'h0);
    end

    // Fill, then clear with a colliding write
    for (int i = 1; i < N; i++) drv(1'b1, 5'(i), 32'(i), 1'b0, 5'(i), 5'd0);
    for (int i = 0; i < N; i++) begin
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(i));
      cmp("fill_rd0", rdata0, 32'(i));
      chk_model();
    end
    drv(1'b1, 5'd3, 32'hFF, 1'b1, 5'd3, 5'd3);
    cmp("clr_drop", {31'h0, wr_drop}, 32'h1);
    chk_model();
    @(posedge clk); #1; clear_req = 1'b0; wen = 1'b0;
    cmp("clr_busy", {31'h0, busy}, 32'h1);
    wait_ready(n);
    cmp("clr_len", n, 32);
    for (int i = 0; i < N; i++) begin
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(i ^ 3));
      cmp("clr_rd0", rdata0, 32'h0);
      chk_model();
    end

    // Refill, then async reset in the middle of a clear
    for (int i = 1; i < N; i++) drv(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'(i), 5'(i));
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    @(posedge clk); #1; clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 cmp("mid_rst_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (n < 200) begin
      wen = 1'b1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
      raddr0 = waddr; raddr1 = 5'($urandom);
      #1; chk_model();
      @(posedge clk); #1; n++;
      if (!busy) break;
      @(negedge clk);
    end
    wen = 1'b0;
    cmp("mid_rst_len", n, 32);
    for (int i = 0; i < N; i++) begin
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
      cmp("mid_rst_rd0", rdata0, 32'h0);
      cmp("mid_rst_rd1", rdata1, 32'h0);
    end

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      drv($urandom_range(0, 3) != 0, wa, $urandom, $urandom_range(0, 63) == 0,
          ($urandom_range(0, 1) != 0) ? wa : 5'($urandom), 5'($urandom));
      chk_model();
    end

    // Small instance: no hardwired zero register
    @(negedge clk); rst_s = 1'b0;
    n = 0;
    while (busy_s && n < 100) begin
      @(posedge clk); #1; n++;
    end
    cmp("s_init_len", n, 8);
    @(negedge clk); wen_s = 1'b1; wa_s = 3'd0; wd_s = 16'hBEEF; ra0_s = 3'd0; ra1_s = 3'd7;
    #1;
    cmp("s_same_rd0", {16'h0, rd0_s}, BYP ? 32'hBEEF : 32'h0);
    cmp("s_same_rd1", {16'h0, rd1_s}, 32'h0);
    cmp("s_drop", {31'h0, drop_s}, 32'h0);
    @(negedge clk); wen_s = 1'b1; wa_s = 3'd7; wd_s = 16'h1234; ra0_s = 3'd0; ra1_s = 3'd0;
    #1;
    cmp("s_r0_rd0", {16'h0, rd0_s}, 32'hBEEF);
    cmp("s_r0_rd1", {16'h0, rd1_s}, 32'hBEEF);
    @(negedge clk); wen_s = 1'b0; ra0_s = 3'd7; ra1_s = 3'd0;
    #1;
    cmp("s_r7", {16'h0, rd0_s}, 32'h1234);
    cmp("s_r0_again", {16'h0, rd1_s}, 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
